dds_sweep_ctrl: RTL and testbench

Frequency-sweep controller sitting directly upstream of the DDS waveform core. Generates the 32-bit frequency tuning word K and the 11-bit phase offset P that the DDS core registers each clock. Steps K linearly from a start word to a stop word, holding each value for a programmable dwell. Supports single-shot and auto-repeat sweeps, with a start/abort control interface and busy/done status.

---
 rtl/dds_pkg.sv | 15 +
 rtl/dds_dwell_cnt.sv | 28 ++
 rtl/dds_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller and the DDS waveform core.
package dds_pkg;

   // Tuning word and phase offset widths, shared with the DDS core
   localparam int K_W = 32;
   localparam int P_W = 11;

   // Sweep controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sweep_state_t;

endpackage : dds_pkg

// File: rtl/dds_dwell_cnt.sv
// Dwell down-counter: parallel load, decrement that stops at zero, zero flag.
module dds_dwell_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   // Load has priority over decrement; decrement never wraps below zero
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule : dds_dwell_cnt

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller: steps the DDS tuning word K from a start word to
// a stop word, holding each value for a programmable dwell, with single-shot
// or auto-repeat sweeps and a start/abort control interface.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int DWELL_W = 16,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               repeat_en,
   input  logic [K_W-1:0]     k_start,
   input  logic [K_W-1:0]     k_step,
   input  logic [K_W-1:0]     k_stop,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [P_W-1:0]     p_init,
   output logic [K_W-1:0]     K,
   output logic [P_W-1:0]     P,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sweep_cnt
);

   sweep_state_t       state;

   // Configuration captured when a sweep is accepted
   logic               rep_q;
   logic [K_W-1:0]     k_start_q;
   logic [K_W-1:0]     k_step_q;
   logic [K_W-1:0]     k_stop_q;
   logic [DWELL_W-1:0] dwell_rld_q;

   logic [K_W:0]       next_sum;
   logic               step_ok;
   logic               accept;
   logic               in_run;
   logic [DWELL_W-1:0] dwell_m1;
   logic               cnt_load;
   logic               cnt_dec;
   logic [DWELL_W-1:0] cnt_val;
   logic [DWELL_W-1:0] cnt;
   logic               cnt_zero;

   // A dwell of 0 behaves as 1, so the reload value is max(dwell,1)-1
   assign dwell_m1 = (dwell == '0) ? '0 : dwell - 1'b1;

   // 33-bit add so an overflowing step is seen as the end of the sweep
   assign next_sum = {1'b0, K} + {1'b0, k_step_q};
   assign step_ok  = !next_sum[K_W] && (next_sum[K_W-1:0] <= k_stop_q);

   assign accept = (state == IDLE) && start && !abort;
   assign in_run = (state == RUN) && !abort;

   // Counter control: load on accept or at end of a dwell that continues
   // the sweep, otherwise count down while running
   assign cnt_load = accept || (in_run && cnt_zero && (step_ok || rep_q));
   assign cnt_dec  = in_run && !cnt_zero;
   assign cnt_val  = (state == IDLE) ? dwell_m1 : dwell_rld_q;

   dds_dwell_cnt #(
      .W (DWELL_W)
   ) u_dwell_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // Sweep FSM with registered K, P and status outputs; abort overrides all
   // NOTE: asynchronous reset clears only control/config registers; there is no memory array to reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         K           <= '0;
         P           <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         sweep_cnt   <= '0;
         rep_q       <= 1'b0;
         k_start_q   <= '0;
         k_step_q    <= '0;
         k_stop_q    <= '0;
         dwell_rld_q <= '0;
      end else if (abort) begin
         state <= IDLE;
         K     <= '0;
         P     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rep_q       <= repeat_en;
                  k_start_q   <= k_start;
                  k_step_q    <= k_step;
                  k_stop_q    <= k_stop;
                  dwell_rld_q <= dwell_m1;
                  K           <= k_start;
                  P           <= p_init;
                  sweep_cnt   <= '0;
                  busy        <= 1'b1;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (cnt_zero) begin
                  if (step_ok) begin
                     K <= next_sum[K_W-1:0];
                  end else if (rep_q) begin
                     K         <= k_start_q;
                     sweep_cnt <= sweep_cnt + 1'b1;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : dds_sweep_ctrl

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl. Inputs change and outputs
// are sampled just after the falling clock edge.
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        repeat_en;
   logic [31:0] k_start;
   logic [31:0] k_step;
   logic [31:0] k_stop;
   logic [15:0] dwell;
   logic [10:0] p_init;
   logic [31:0] K;
   logic [10:0] P;
   logic        busy;
   logic        done;
   logic [7:0]  sweep_cnt;

   int errors = 0;
   int checks = 0;
   int done_hi = 0;

   always #5 clk = ~clk;

   dds_sweep_ctrl #(
      .DWELL_W (16),
      .CNT_W   (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .repeat_en (repeat_en),
      .k_start   (k_start),
      .k_step    (k_step),
      .k_stop    (k_stop),
      .dwell     (dwell),
      .p_init    (p_init),
      .K         (K),
      .P         (P),
      .busy      (busy),
      .done      (done),
      .sweep_cnt (sweep_cnt)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic set_cfg(input logic [31:0] ks, input logic [31:0] kp, input logic [31:0] ke,
                          input logic [15:0] dw, input logic rp, input logic [10:0] pi);
      k_start   = ks;
      k_step    = kp;
      k_stop    = ke;
      dwell     = dw;
      repeat_en = rp;
      p_init    = pi;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_k"}, K, 32'd0);
      check({tag, "_p"}, {21'd0, P}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_cnt"}, {24'd0, sweep_cnt}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      set_cfg(32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 11'd0);
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Single sweep 100..250 step 50, dwell 3; a start pulse with different
      // configuration arrives mid-sweep and must be ignored
      set_cfg(32'd100, 32'd50, 32'd250, 16'd3, 1'b0, 11'h155);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check("t1_k", K, 32'(100 + 50 * (i / 3)));
         check("t1_p", {21'd0, P}, 32'h155);
         check("t1_busy", {31'd0, busy}, 32'd1);
         check("t1_done", {31'd0, done}, 32'd0);
         if (i == 4) begin
            start = 1'b1;
            set_cfg(32'd999, 32'd1, 32'd5000, 16'd7, 1'b1, 11'h0);
         end
         if (i == 5) start = 1'b0;
         @(negedge clk);
      end
      check("t1_done_pulse", {31'd0, done}, 32'd1);
      check("t1_done_busy", {31'd0, busy}, 32'd0);
      check("t1_done_k", K, 32'd250);
      @(negedge clk);
      check("t1_after_done", {31'd0, done}, 32'd0);
      check("t1_after_k", K, 32'd250);
      check("t1_after_p", {21'd0, P}, 32'h155);
      repeat (3) @(negedge clk);
      check("t1_idle_k", K, 32'd250);

      // Abort in the second dwell
      set_cfg(32'd100, 32'd50, 32'd250, 16'd3, 1'b0, 11'h155);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("ab_k_before", K, 32'd150);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("ab_k", K, 32'd0);
      check("ab_p", {21'd0, P}, 32'd0);
      check("ab_busy", {31'd0, busy}, 32'd0);
      check("ab_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 12; i++) begin
         check("ab_no_done", {31'd0, done}, 32'd0);
         @(negedge clk);
      end
      check("ab_idle_k", K, 32'd0);

      // Start and abort together in IDLE: abort wins
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", {31'd0, busy}, 32'd0);
      check("sa_k", K, 32'd0);
      @(negedge clk);
      check("sa_busy2", {31'd0, busy}, 32'd0);
      check("sa_k2", K, 32'd0);

      // Overflowing step with dwell 0: one cycle of k_start, then DONE
      set_cfg(32'hFFFF_FF00, 32'h200, 32'hFFFF_FFFF, 16'd0, 1'b0, 11'h7FF);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ov_k", K, 32'hFFFF_FF00);
      check("ov_p", {21'd0, P}, 32'h7FF);
      check("ov_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("ov_done", {31'd0, done}, 32'd1);
      check("ov_busy_done", {31'd0, busy}, 32'd0);
      check("ov_k_done", K, 32'hFFFF_FF00);

      // Start held from the DONE cycle: ignored in DONE, accepted in IDLE;
      // new configuration has k_start > k_stop with dwell 2
      set_cfg(32'd500, 32'd1, 32'd200, 16'd2, 1'b0, 11'h0AA);
      start = 1'b1;
      @(negedge clk);
      check("rs_done_low", {31'd0, done}, 32'd0);
      check("rs_busy_low", {31'd0, busy}, 32'd0);
      check("rs_k_hold", K, 32'hFFFF_FF00);
      @(negedge clk);
      start = 1'b0;
      check("rs_k", K, 32'd500);
      check("rs_p", {21'd0, P}, 32'h0AA);
      check("rs_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("rs_k2", K, 32'd500);
      check("rs_done2", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("rs_done", {31'd0, done}, 32'd1);
      check("rs_k_done", K, 32'd500);
      @(negedge clk);
      check("rs_done_end", {31'd0, done}, 32'd0);

      // Auto-repeat 10,20,30 with dwell 1 through a sweep_cnt wrap
      set_cfg(32'd10, 32'd10, 32'd30, 16'd1, 1'b1, 11'h0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check("rp_k", K, 32'(10 + 10 * (i % 3)));
         check("rp_cnt", {24'd0, sweep_cnt}, 32'(i / 3));
         check("rp_done", {31'd0, done}, 32'd0);
         @(negedge clk);
      end
      repeat (756) begin
         if (done) done_hi++;
         @(negedge clk);
      end
      check("rp_cnt_255", {24'd0, sweep_cnt}, 32'd255);
      check("rp_k_255", K, 32'd10);
      check("rp_never_done", 32'(done_hi), 32'd0);
      repeat (3) @(negedge clk);
      check("rp_cnt_wrap", {24'd0, sweep_cnt}, 32'd0);
      check("rp_k_wrap", K, 32'd10);
      check("rp_busy", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("rp_abort_busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of a dwell
      set_cfg(32'd100, 32'd50, 32'd250, 16'd3, 1'b0, 11'h155);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("ar_k_before", K, 32'd100);
      #2 rst_n = 1'b0;
      #1 check_all_zero("ar");
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ar_restart_k", K, 32'd100);
      check("ar_restart_p", {21'd0, P}, 32'h155);
      check("ar_restart_busy", {31'd0, busy}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dds_sweep_ctrl
